bp_unit: RTL

Hardware PC breakpoint unit on the debug path beside the CPU fetch stage. It debounces the two board push-buttons and assembles a breakpoint address one hex nibble at a time from the switches. It compares that address against the fetch PC and raises a halt request on a match. Its outputs feed the seven-segment debug mux (breakpoint value) and the pipeline stall/clock-enable logic (halt request, hit LED).

---
 rtl/bp_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/bp_unit.sv
// PC breakpoint unit: debounced buttons load a 32-bit breakpoint one nibble at
// a time, and a small FSM raises halt_req when the fetch PC matches it.
module bp_debounce #(
  parameter int DB_CYCLES = 50000,
  parameter int DB_W      = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);
  logic [1:0]      sync;
  logic            level, level_d;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync    <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else begin
      sync    <= {sync[0], raw};
      level_d <= level;
      pulse   <= level & ~level_d;
      // Any reversal back to the accepted level restarts the stability count.
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DB_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module bp_unit #(
  parameter int DB_CYCLES = 50000,
  parameter int DB_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_btn,
  input  logic        sample_btn,
  input  logic [2:0]  digit_sel,
  input  logic [3:0]  hex_digit,
  input  logic [29:0] pc,
  input  logic        pc_valid,
  output logic [31:0] break_point,
  output logic        armed,
  output logic        hit,
  output logic        halt_req,
  output logic [7:0]  hit_count
);
  localparam int NUM_BTN = 2;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_HIT   = 2'd2;
  localparam logic [1:0] S_SKIP  = 2'd3;

  logic [NUM_BTN-1:0] btn_raw, btn_pulse;
  logic               v_pulse, s_pulse;
  logic [1:0]         state;
  logic               pc_eq, match;

  assign btn_raw = {sample_btn, valid_btn};

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    bp_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_raw[b]),
      .pulse (btn_pulse[b])
    );
  end

  assign v_pulse = btn_pulse[0];
  assign s_pulse = btn_pulse[1];
  assign pc_eq   = (pc == break_point[31:2]);
  assign match   = pc_valid && pc_eq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      break_point <= '0;
      hit_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (s_pulse) break_point[{digit_sel, 2'b00} +: 4] <= hex_digit;
          if (v_pulse) state <= S_ARMED;
        end
        S_ARMED: begin
          if (v_pulse) begin
            state <= S_IDLE;
          end else if (match) begin
            state <= S_HIT;
            if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
          end
        end
        S_HIT: begin
          if (s_pulse) break_point[{digit_sel, 2'b00} +: 4] <= hex_digit;
          if (v_pulse) state <= S_SKIP;
        end
        S_SKIP: begin
          // Stay parked until the pipeline has fetched past the breakpoint.
          if (v_pulse)                 state <= S_IDLE;
          else if (pc_valid && !pc_eq) state <= S_ARMED;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign armed    = (state == S_ARMED);
  assign hit      = (state == S_HIT);
  assign halt_req = hit;
endmodule
